// File: rtl/regfile_multiport_sb_pkg.sv
// Shared definitions for the multiport register file:
// sweep/run state encoding, default geometry and a port slice helper.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;

  // Low bit of port 'idx' inside a packed bus of 'width'-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_multiport_sb_if.sv
// Decode/writeback side bundle of the register file.
//   master : decode/writeback stage (drives addresses, write data, issue)
//   slave  : register file (returns read data, busy flags, Ready)
// Signals: SoftClr, RA, BusR, RdBusy, RW, BusW, RegWr, IssueWr, IssueRd, Ready.
interface regfile_multiport_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD
);
  logic                       SoftClr;
  logic [NUM_RD*ADDR_W-1:0]   RA;
  logic [NUM_RD*DATA_W-1:0]   BusR;
  logic [NUM_RD-1:0]          RdBusy;
  logic [ADDR_W-1:0]          RW;
  logic [DATA_W-1:0]          BusW;
  logic                       RegWr;
  logic                       IssueWr;
  logic [ADDR_W-1:0]          IssueRd;
  logic                       Ready;

  modport master (
    output SoftClr, RA, RW, BusW, RegWr, IssueWr, IssueRd,
    input  BusR, RdBusy, Ready
  );

  modport slave (
    input  SoftClr, RA, RW, BusW, RegWr, IssueWr, IssueRd,
    output BusR, RdBusy, Ready
  );
endinterface

// File: rtl/regfile_multiport_sb_scoreboard.sv
// Busy scoreboard: one bit per register, bit 0 is always 0.
// Ports:
//   clk, rst  : clock, async active-high reset (clears all bits)
//   clr_all   : synchronous clear of every bit (highest priority)
//   set_en/set_addr : mark a register busy (producer issued)
//   clr_en/clr_addr : mark a register free (writeback)
//   busy      : current busy vector
module regfile_scoreboard #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_all,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic [(1<<ADDR_W)-1:0]   busy
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (clr_all) begin
      busy <= '0;
    end else begin
      // Bit 0 is never touched, so it stays at its reset value of 0.
      // Set is tested first: a newly issued producer supersedes a
      // same-cycle writeback to the same register.
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (set_en && set_addr == ADDR_W'(i)) begin
          busy[i] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_multiport_sb.sv
// Multiport register file with write bypass and busy scoreboard.
// NUM_RD combinational read ports, one synchronous write port. After reset
// or SoftClr a sweep zeroes one register per cycle; Ready rises once the
// whole array has been cleared. Register 0 always reads 0.
// Ports:
//   Clk   : clock
//   Reset : async active-high reset
//   bus   : slave side of regfile_multiport_sb_if (reads, write, issue, Ready)
module regfile_multiport_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  regfile_multiport_sb_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic                run;
  logic                soft_clr;
  logic                wr_en;
  logic                issue_en;

  assign run      = (state_q == ST_RUN);
  assign soft_clr = run && bus.SoftClr;
  // A soft clear discards the write and issue presented with it.
  assign wr_en    = run && !bus.SoftClr && bus.RegWr && (bus.RW != '0);
  assign issue_en = run && !bus.SoftClr && bus.IssueWr && (bus.IssueRd != '0);
  assign bus.Ready = run;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.SoftClr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Array has no reset; the sweep is what zeroes it.
  always_ff @(posedge Clk) begin
    if (!run) begin
      regs[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      regs[bus.RW] <= bus.BusW;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (Reset),
    .clr_all  (soft_clr),
    .set_en   (issue_en),
    .set_addr (bus.IssueRd),
    .clr_en   (wr_en),
    .clr_addr (bus.RW),
    .busy     (busy)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign ra  = bus.RA[slice_lo(g, ADDR_W) +: ADDR_W];
    assign hit = (BYPASS != 0) && bus.RegWr && (bus.RW == ra) && (ra != '0);

    always_comb begin
      data = '0;
      if (run && ra != '0) begin
        data = hit ? bus.BusW : regs[ra];
      end
    end

    assign bus.BusR[slice_lo(g, DATA_W) +: DATA_W] = data;
    // Bypassed data is already current, so the port is not stalled.
    assign bus.RdBusy[g] = run && busy[ra] && !hit;
  end
endmodule

// File: tb/tb_regfile_multiport_sb.sv
module tb_regfile_multiport_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_multiport_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_byp ();
  regfile_multiport_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_nob ();

  regfile_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_byp (
    .Clk(clk), .Reset(rst), .bus(if_byp.slave));
  regfile_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_nob (
    .Clk(clk), .Reset(rst), .bus(if_nob.slave));

  // Shared stimulus
  logic        sc = 1'b0, regwr = 1'b0, iw = 1'b0;
  logic [4:0]  ra0 = '0, ra1 = '0, rw = '0, ird = '0;
  logic [31:0] busw = '0;

  assign if_byp.SoftClr = sc;   assign if_nob.SoftClr = sc;
  assign if_byp.RA = {ra1, ra0}; assign if_nob.RA = {ra1, ra0};
  assign if_byp.RW = rw;         assign if_nob.RW = rw;
  assign if_byp.BusW = busw;     assign if_nob.BusW = busw;
  assign if_byp.RegWr = regwr;   assign if_nob.RegWr = regwr;
  assign if_byp.IssueWr = iw;    assign if_nob.IssueWr = iw;
  assign if_byp.IssueRd = ird;   assign if_nob.IssueRd = ird;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  bit          m_run;
  int          m_ptr;

  task automatic model_reset();
    m_run = 0;
    m_ptr = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      m_regs[m_ptr] = '0;
      if (m_ptr == 31) m_run = 1;
      m_ptr = (m_ptr + 1) % 32;
    end else if (sc) begin
      model_reset();
    end else begin
      if (regwr && rw != 0) begin
        m_regs[rw] = busw;
        m_busy[rw] = 1'b0;
      end
      if (iw && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t exp_q [$];

  task automatic push_exp(input bit byp, input string pfx);
    logic [4:0]  ra;
    logic [31:0] d;
    logic        b;
    bit          hit;
    for (int p = 0; p < 2; p++) begin
      ra  = (p == 0) ? ra0 : ra1;
      hit = byp && regwr && (rw == ra) && (ra != 0);
      d   = '0;
      b   = 1'b0;
      if (m_run && ra != 0) begin
        d = hit ? busw : m_regs[ra];
        b = m_busy[ra] && !hit;
      end
      exp_q.push_back('{tag: $sformatf("%s_busr%0d_ra%0d", pfx, p, ra), exp: d});
      exp_q.push_back('{tag: $sformatf("%s_rdbusy%0d_ra%0d", pfx, p, ra), exp: {31'b0, b}});
    end
    exp_q.push_back('{tag: {pfx, "_ready"}, exp: {31'b0, m_run}});
  endtask

  task automatic pop_cmp(input logic [63:0] bus_r, input logic [1:0] rd_busy, input logic ready);
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front(); chk(e.tag, bus_r[p*32 +: 32], e.exp);
      e = exp_q.pop_front(); chk(e.tag, {31'b0, rd_busy[p]}, e.exp);
    end
    e = exp_q.pop_front(); chk(e.tag, {31'b0, ready}, e.exp);
  endtask

  // Called at a negedge: applies inputs, checks combinational outputs,
  // then advances the model across the next posedge.
  task automatic step(input logic i_sc, input logic [4:0] i_ra0, input logic [4:0] i_ra1,
                      input logic [4:0] i_rw, input logic [31:0] i_busw, input logic i_regwr,
                      input logic i_iw, input logic [4:0] i_ird);
    sc = i_sc; ra0 = i_ra0; ra1 = i_ra1; rw = i_rw; busw = i_busw;
    regwr = i_regwr; iw = i_iw; ird = i_ird;
    if (rst) model_reset();
    push_exp(1'b1, "byp");
    push_exp(1'b0, "nob");
    #2;
    pop_cmp(if_byp.BusR, if_byp.RdBusy, if_byp.Ready);
    pop_cmp(if_nob.BusR, if_nob.RdBusy, if_nob.Ready);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    idle(2);
    rst = 1'b0;

    // Sweep after reset: Ready low for 32 cycles, then high
    idle(33);

    // Every address reads 0 on both ports
    for (int a = 0; a < 32; a++)
      step(1'b0, 5'(a), 5'(31 - a), 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Write with same-cycle read, then the following cycle
    step(1'b0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0);
    step(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Register 0 ignores write and issue
    step(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Scoreboard: issue, writeback, simultaneous issue+writeback
    step(1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    step(1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 1'b1, 1'b0, 5'd0);
    step(1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    step(1'b0, 5'd7, 5'd7, 5'd7, 32'hCAFEF00D, 1'b1, 1'b1, 5'd7);
    step(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Soft clear mid-run with a concurrent write
    step(1'b0, 5'd0, 5'd0, 5'd3, 32'h33333333, 1'b1, 1'b0, 5'd0);
    step(1'b0, 5'd0, 5'd0, 5'd9, 32'h99999999, 1'b1, 1'b1, 5'd4);
    step(1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd3, 5'd9, 5'd3, 32'h1, 1'b1, 1'b1, 5'd5);
    for (int i = 0; i < 33; i++) step(1'b0, 5'd3, 5'd9, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd4, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Mixed traffic
    for (int i = 0; i < 60; i++)
      step(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

    // Reset at sweep cycle 10 restarts the full sweep
    step(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    idle(10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(34);
    for (int a = 0; a < 32; a++)
      step(1'b0, 5'(a), 5'(31 - a), 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
